// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus a 16-byte MMIO
// window with a cycle counter, tohost mailbox and sticky status/error flags.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] tohost_o,
  output logic        tohost_valid_o,
  output logic        halt_o,
  output logic        err_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [1:0]  REG_CYCLE  = 2'd0;
  localparam logic [1:0]  REG_TOHOST = 2'd1;
  localparam logic [1:0]  REG_STATUS = 2'd2;
  localparam logic [1:0]  REG_ERRCLR = 2'd3;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   tohost_q, tohost_d;
  logic          tohost_valid_q, tohost_valid_d;
  logic          halt_q, halt_d;
  logic          mis_q, mis_d;
  logic          oor_q, oor_d;
  logic          err_q, err_d;

  logic          misalign_c;
  logic          ram_hit_c;
  logic          mmio_hit_c;
  logic [29:0]   mmio_woff_c;
  logic [1:0]    reg_sel_c;
  logic [AW-1:0] ram_idx_c;
  logic          mem_we_c;
  logic [31:0]   status_c;

  // Address decode; the MMIO offset is taken in words so any base works.
  always_comb begin
    misalign_c  = (addr_i[1:0] != 2'b00);
    ram_hit_c   = (addr_i < RAM_BYTES);
    mmio_woff_c = addr_i[31:2] - MMIO_BASE[31:2];
    mmio_hit_c  = (mmio_woff_c[29:2] == 28'd0);
    reg_sel_c   = mmio_woff_c[1:0];
    ram_idx_c   = addr_i[AW+1:2];
    status_c    = {29'd0, oor_q, mis_q, halt_q};
  end

  // Combinational load path.
  always_comb begin
    rdata_o = 32'd0;
    if (ce_i && !we_i && !misalign_c) begin
      if (ram_hit_c) begin
        rdata_o = mem_q[ram_idx_c];
      end else if (mmio_hit_c) begin
        case (reg_sel_c)
          REG_CYCLE:  rdata_o = cycle_q;
          REG_TOHOST: rdata_o = tohost_q;
          REG_STATUS: rdata_o = status_c;
          default:    rdata_o = 32'd0;
        endcase
      end
    end
  end

  // Next-state for MMIO registers, sticky flags and the RAM write strobe.
  always_comb begin
    cycle_d        = halt_q ? cycle_q : cycle_q + 32'd1;
    tohost_d       = tohost_q;
    tohost_valid_d = 1'b0;
    halt_d         = halt_q;
    mis_d          = mis_q;
    oor_d          = oor_q;
    mem_we_c       = 1'b0;
    if (ce_i) begin
      if (misalign_c) begin
        mis_d = 1'b1;
      end else if (!ram_hit_c && !mmio_hit_c) begin
        oor_d = 1'b1;
      end else if (we_i && !halt_q) begin
        if (ram_hit_c) begin
          mem_we_c = 1'b1;
        end else begin
          case (reg_sel_c)
            REG_TOHOST: begin
              tohost_d       = wdata_i;
              tohost_valid_d = 1'b1;
              if (wdata_i[0]) halt_d = 1'b1;
            end
            REG_ERRCLR: begin
              mis_d = 1'b0;
              oor_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
    err_d = mis_d | oor_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q        <= 32'd0;
      tohost_q       <= 32'd0;
      tohost_valid_q <= 1'b0;
      halt_q         <= 1'b0;
      mis_q          <= 1'b0;
      oor_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      cycle_q        <= cycle_d;
      tohost_q       <= tohost_d;
      tohost_valid_q <= tohost_valid_d;
      halt_q         <= halt_d;
      mis_q          <= mis_d;
      oor_q          <= oor_d;
      err_q          <= err_d;
    end
  end

  // RAM is not reset; a store coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (mem_we_c && rst_n) begin
      mem_q[ram_idx_c] <= wdata_i;
    end
  end

  assign tohost_o       = tohost_q;
  assign tohost_valid_o = tohost_valid_q;
  assign halt_o         = halt_q;
  assign err_o          = err_q;

endmodule
